// File: rtl/data_compare_pkg.sv
// Shared definitions for the multi-cycle magnitude comparator:
// one-hot result encodings and the sequencer state type.
package data_compare_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/chunk_compare.sv
// Combinational CHUNK-bit unsigned compare. Optionally flips the MSB of both
// operands, which maps two's-complement ordering onto unsigned ordering.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_inv_msb,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  logic [CHUNK-1:0] w_msk;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  assign w_msk = CHUNK'(i_inv_msb) << (CHUNK - 1);
  assign w_a   = i_a ^ w_msk;
  assign w_b   = i_b ^ w_msk;

  assign o_gt = (w_a > w_b);
  assign o_eq = (w_a == w_b);
  assign o_lt = (w_a < w_b);

endmodule

// File: rtl/data_compare_seq.sv
// Sequential magnitude comparator: latches two WIDTH-bit operands and compares
// them CHUNK bits per cycle from the MSB chunk, stopping at the first difference.
module data_compare_seq
  import data_compare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iStart,
  input  logic                            iSigned,
  input  logic [WIDTH-1:0]                iData_a,
  input  logic [WIDTH-1:0]                iData_b,
  output logic                            oBusy,
  output logic                            oValid,
  output logic [2:0]                      oData,
  output logic [$clog2(WIDTH/CHUNK):0]    oCycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = $clog2(NCHUNK) + 1;

  generate
    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("data_compare_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_valid;
  logic [2:0]       r_data;
  logic [CW-1:0]    r_cycles;

  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic             w_inv_msb;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;

  // Only the most significant chunk carries the sign bit.
  assign w_chunk_a = r_a[int'(r_idx) * CHUNK +: CHUNK];
  assign w_chunk_b = r_b[int'(r_idx) * CHUNK +: CHUNK];
  assign w_inv_msb = r_signed && (r_idx == IW'(NCHUNK - 1));

  chunk_compare #(
    .CHUNK (CHUNK)
  ) u_chunk_compare (
    .i_a       (w_chunk_a),
    .i_b       (w_chunk_b),
    .i_inv_msb (w_inv_msb),
    .o_gt      (w_gt),
    .o_eq      (w_eq),
    .o_lt      (w_lt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 3'b000;
      r_cycles <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_a      <= iData_a;
            r_b      <= iData_b;
            r_signed <= iSigned;
            r_idx    <= IW'(NCHUNK - 1);
            r_cnt    <= CW'(1);
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (!w_eq) begin
            r_data   <= w_gt ? CMP_GT : (w_lt ? CMP_LT : CMP_EQ);
            r_cycles <= r_cnt;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (r_idx == '0) begin
            r_data   <= CMP_EQ;
            r_cycles <= r_cnt;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_idx <= r_idx - IW'(1);
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oBusy   = r_busy;
  assign oValid  = r_valid;
  assign oData   = r_data;
  assign oCycles = r_cycles;

endmodule

// File: tb/tb_data_compare_seq.sv
// Self-checking bench for data_compare_seq: a scoreboard of model results is
// filled when a start is accepted and drained whenever oValid pulses.
module tb_data_compare_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iStart;
  logic             iSigned;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic             oBusy;
  logic             oValid;
  logic [2:0]       oData;
  logic [CW-1:0]    oCycles;

  typedef struct {
    string      tag;
    logic [2:0] data;
    int         cycles;
    int         start_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  data_compare_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iSigned (iSigned),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .oBusy   (oBusy),
    .oValid  (oValid),
    .oData   (oData),
    .oCycles (oCycles)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: full-width compare for the verdict; the highest differing bit
  // tells which chunk (from the MSB) decides it.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [2:0] d, output int c);
    logic [31:0] x;
    x = a ^ b;
    c = NCHUNK;
    if (x == '0) begin
      d = 3'b010;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (x[i]) c = NCHUNK - i / CHUNK;
      if (s ? ($signed(a) > $signed(b)) : (a > b)) d = 3'b100;
      else d = 3'b001;
    end
  endfunction

  always @(negedge iClk) begin : monitor
    exp_t e;
    if (!iRst && oValid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_data"},    32'(oData),   32'(e.data));
        check({e.tag, "_cycles"},  32'(oCycles), e.cycles);
        check({e.tag, "_latency"}, cyc - e.start_cyc - 1, e.cycles);
        check({e.tag, "_busy"},    32'(oBusy),   32'd0);
      end
    end
  end

  // Call at a negedge; returns just after the sampling edge.
  task automatic start_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
    exp_t e;
    iData_a = a;
    iData_b = b;
    iSigned = s;
    iStart  = 1'b1;
    if (!oBusy && !iRst) begin
      model(a, b, s, e.data, e.cycles);
      e.tag       = tag;
      e.start_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge iClk);
    #1 iStart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0 && !oBusy) begin
        done = 1'b1;
        break;
      end
      @(negedge iClk);
    end
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          got_valid;

    iRst    = 1'b1;
    iStart  = 1'b0;
    iSigned = 1'b0;
    iData_a = '0;
    iData_b = '0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("rst_busy",   32'(oBusy),   32'd0);
    check("rst_valid",  32'(oValid),  32'd0);
    check("rst_data",   32'(oData),   32'd0);
    check("rst_cycles", 32'(oCycles), 32'd0);
    iRst = 1'b0;

    @(negedge iClk); start_cmp("gt_top",  32'h2400_0000, 32'h1200_0000, 1'b0); wait_done("gt_top");
    @(negedge iClk); start_cmp("lt_low",  32'h0000_0008, 32'h0000_0010, 1'b0); wait_done("lt_low");
    @(negedge iClk); start_cmp("eq_all",  32'h1212_1212, 32'h1212_1212, 1'b0); wait_done("eq_all");
    @(negedge iClk); start_cmp("signed",  32'h8000_0000, 32'h0000_0001, 1'b1); wait_done("signed");
    @(negedge iClk); start_cmp("unsign",  32'h8000_0000, 32'h0000_0001, 1'b0); wait_done("unsign");

    // A start while busy must neither re-sample nor produce a second result.
    @(negedge iClk); start_cmp("hold", 32'h0000_0001, 32'h0000_0001, 1'b0);
    @(negedge iClk);
    check("busy_in_run", 32'(oBusy), 32'd1);
    start_cmp("ignored", 32'hFF00_0000, 32'h0000_0000, 1'b0);
    wait_done("hold");

    // Start in the oValid cycle: second result must follow with no bubble.
    @(negedge iClk); start_cmp("b2b_first", 32'h0011_0000, 32'h0022_0000, 1'b0);
    got_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (oValid) begin
        got_valid = 1'b1;
        break;
      end
    end
    if (!got_valid) check("b2b_wait_timeout", 32'd1, 32'd0);
    start_cmp("b2b_second", 32'h7F00_0000, 32'h8000_0000, 1'b1);
    wait_done("b2b");

    // Reset during the second RUN cycle of a 4-chunk equal compare.
    @(negedge iClk); start_cmp("aborted", 32'hABCD_1234, 32'hABCD_1234, 1'b0);
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    void'(sb_q.pop_back());
    @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    check("abort_busy",   32'(oBusy),   32'd0);
    check("abort_valid",  32'(oValid),  32'd0);
    check("abort_data",   32'(oData),   32'd0);
    check("abort_cycles", 32'(oCycles), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge iClk);
      check("abort_no_valid", 32'(oValid), 32'd0);
    end

    // Reset wins over a simultaneous start.
    @(negedge iClk);
    iRst = 1'b1;
    start_cmp("rst_vs_start", 32'h0000_0001, 32'h0000_0002, 1'b0);
    iRst = 1'b0;
    @(negedge iClk);
    check("rst_prio_busy", 32'(oBusy), 32'd0);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(2, 0))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(31, 0));
        default: rb = $urandom;
      endcase
      @(negedge iClk);
      start_cmp("rand", ra, rb, 1'($urandom_range(1, 0)));
      wait_done("rand");
    end

    repeat (3) @(negedge iClk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_compare_seq.md
# data_compare_seq

Parametrised, multi-cycle magnitude comparator: the sequential successor of the 8-bit combinational comparator. It latches two WIDTH-bit operands on a start strobe and compares them CHUNK bits per cycle, most significant chunk first. It stops early at the first differing chunk and reports greater/equal/less in the same 3-bit result encoding. It supports unsigned and two's-complement signed modes and serves wide datapaths where a full-width combinational compare would break timing.

## Interface
- WIDTH, 32, operand width; must be a positive multiple of CHUNK
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK
- iClk  input  1  clock; all state updates on rising edge
- iRst  input  1  reset, synchronous, active-high
- iStart  input  1  request; accepted only when oBusy=0
- iSigned  input  1  1 = two's-complement compare, 0 = unsigned; sampled with iStart
- iData_a  input  WIDTH  operand A; sampled with iStart
- iData_b  input  WIDTH  operand B; sampled with iStart
- oBusy  output  1  comparison in progress
- oValid  output  1  one-cycle pulse: oData/oCycles hold a new result
- oData  output  3  result {A>B, A==B, A<B}; exactly one bit set after the first result
- oCycles  output  clog2(NCHUNK)+1  number of chunks examined for the current result (1..NCHUNK)

## Operation
- States: IDLE, RUN.
- IDLE:
  - On iStart=1, latch iData_a, iData_b and iSigned.
  - Set chunk index = NCHUNK-1 and the examined count = 1.
  - Go to RUN; oBusy=1.
- RUN: compare chunk[idx] of A and B.
  - In signed mode, only the top chunk (idx = NCHUNK-1) has its MSB inverted on both operands before an unsigned compare. Lower chunks are always compared unsigned.
  - If the chunks differ: register oData = 3'b100 (A>B) or 3'b001 (A<B), register oCycles = count, pulse oValid, return to IDLE.
  - If the chunks are equal and idx=0: oData = 3'b010, oCycles = NCHUNK, pulse oValid, return to IDLE.
  - Otherwise: idx−1, count+1, stay in RUN.
- oData and oCycles hold their last value until the next result. They change only on the oValid cycle.
- Boundary rules:
  - iStart while oBusy=1 is ignored; operands are not re-sampled.
  - iStart in the cycle oValid=1 is accepted, because the state is already IDLE. This gives back-to-back operation with no bubble.
  - NCHUNK=1 (CHUNK=WIDTH): every result takes exactly 1 cycle.
  - iRst at any time, including mid-RUN, forces IDLE and clears all outputs. No oValid is produced for the aborted compare.
  - iRst has priority over iStart in the same cycle.

## Timing
- Reset values: oBusy=0, oValid=0, oData=3'b000, oCycles=0.
- Let E0 be the start-acceptance edge. oBusy goes to 1 after E0.
- For a result decided at chunk n (n = 1..NCHUNK, counted from the MSB chunk):
  - oValid=1 and the result appear after edge E0+n.
  - oBusy=0 in that same cycle.
- Latency is 1 to NCHUNK cycles; throughput is one compare per latency cycles.
- oValid is high for exactly one cycle per accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package data_compare_pkg holds:
  - result constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001
  - the state enumeration (IDLE, RUN)
- Sub-module chunk_compare: combinational CHUNK-bit compare.
  - Inputs: two chunks and an invert-MSB flag.
  - Outputs: gt/eq/lt.
  - Instantiated once on the muxed current chunk.
- Top level holds the FSM, operand registers, index/count counters and output registers. The parameter check (WIDTH % CHUNK == 0) is an elaboration-time assertion.

## Test plan
Defaults: WIDTH=32, CHUNK=8.
- Reset: assert iRst for 2 cycles. Expect oBusy=0, oValid=0, oData=000, oCycles=0.
- a=0x24000000, b=0x12000000, unsigned. Expect oValid 1 cycle after start with oData=100 and oCycles=1.
- a=0x00000008, b=0x00000010, unsigned. Expect oValid 4 cycles after start with oData=001 and oCycles=4.
- a=b=0x12121212. Expect oData=010 and oCycles=4.
- a=0x80000000, b=0x00000001:
  - iSigned=1 gives oData=001 with oCycles=1.
  - The same operands with iSigned=0 give oData=100.
- Control timing:
  - Pulse iStart again during RUN with different operands. Expect it ignored and the first result unchanged.
  - Assert iStart in the oValid cycle. Expect the second result exactly its latency later.
  - Assert iRst in the 2nd RUN cycle of a 4-chunk equal compare. Expect oBusy=0 next cycle and no oValid.
